// File: rtl/spi_byte_sequencer_if.sv
// Host and SPI-master facing signals of spi_byte_sequencer.
// The slave modport is the sequencer; master is whoever drives host requests and the byte engine.
interface spi_byte_sequencer_if;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       i_rd_en;
    logic [7:0] o_rd_data;
    logic       o_tx_full;
    logic       o_rx_empty;
    logic       i_go;
    logic [7:0] i_len;
    logic       i_clr_err;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;
    logic       o_overflow;
    logic       o_timeout;
    logic [7:0] o_TX_Byte;
    logic       o_inicio;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en, i_go, i_len, i_clr_err, i_RX_DV, i_RX_Byte,
        output o_rd_data, o_tx_full, o_rx_empty, o_busy, o_done, o_underrun, o_overflow,
        output o_timeout, o_TX_Byte, o_inicio
    );

    modport master (
        output i_wr_en, i_wr_data, i_rd_en, i_go, i_len, i_clr_err, i_RX_DV, i_RX_Byte,
        input  o_rd_data, o_tx_full, o_rx_empty, o_busy, o_done, o_underrun, o_overflow,
        input  o_timeout, o_TX_Byte, o_inicio
    );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Runs multi-byte SPI bursts: feeds TX FIFO bytes to the byte engine one start pulse at a time,
// collects returned bytes into an RX FIFO, and keeps chip select idle between bytes.
module spi_byte_sequencer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned GAP_CLKS     = 4,
    parameter int unsigned TIMEOUT_CLKS = 20000,
    parameter logic [7:0]  FILL_BYTE    = 8'h00
) (
    input logic                  Clk,
    input logic                  rst,
    spi_byte_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned GW = $clog2(GAP_CLKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_e;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;

    state_e        state_q;
    logic [7:0]    remaining_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [7:0]    tx_byte_q;
    logic          inicio_q, done_q, busy_q;
    logic          underrun_q, overflow_q, timeout_q;

    logic tx_push, tx_pop, rx_push, rx_pop;

    // FIFO strobes: a full TX FIFO drops the write even when the sequencer pops the same cycle.
    always_comb begin
        tx_push = bus.i_wr_en && (tx_cnt_q != CW'(DEPTH));
        tx_pop  = (state_q == S_LOAD) && (tx_cnt_q != '0);
        rx_push = (state_q == S_WAIT) && bus.i_RX_DV && (rx_cnt_q != CW'(DEPTH));
        rx_pop  = bus.i_rd_en && (rx_cnt_q != '0);
    end

    always_ff @(posedge Clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.i_wr_data;
        if (rx_push) rx_mem[rx_wp_q] <= bus.i_RX_Byte;
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Burst sequencer; the timeout count equals cycles elapsed since the start pulse.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            tx_byte_q   <= '0;
            inicio_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            inicio_q <= 1'b0;
            done_q   <= 1'b0;
            if (bus.i_clr_err) begin
                underrun_q <= 1'b0;
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.i_go) begin
                        if (bus.i_len != 8'd0) begin
                            state_q     <= S_LOAD;
                            remaining_q <= bus.i_len;
                            busy_q      <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (tx_pop) begin
                        tx_byte_q <= tx_mem[tx_rp_q];
                    end else begin
                        tx_byte_q  <= FILL_BYTE;
                        underrun_q <= 1'b1;
                    end
                    inicio_q <= 1'b1;
                    state_q  <= S_START;
                end
                S_START: begin
                    tmo_cnt_q <= TW'(1);
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_RX_DV) begin
                        if (rx_cnt_q == CW'(DEPTH)) overflow_q <= 1'b1;
                        remaining_q <= remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= '0;
                        end
                    end else if (tmo_cnt_q == TW'(TIMEOUT_CLKS - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CLKS - 1)) state_q <= S_LOAD;
                    else                                 gap_cnt_q <= gap_cnt_q + GW'(1);
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rd_data  = (rx_cnt_q == '0) ? 8'h00 : rx_mem[rx_rp_q];
    assign bus.o_tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign bus.o_rx_empty = (rx_cnt_q == '0);
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_underrun = underrun_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_TX_Byte  = tx_byte_q;
    assign bus.o_inicio   = inicio_q;
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Scoreboard bench for spi_byte_sequencer with a loopback byte engine (returns TX ^ 8'hFF).
module tb_spi_byte_sequencer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TMO   = 300;
    localparam logic [7:0]  FILL  = 8'h00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_byte_sequencer_if bus ();

    spi_byte_sequencer #(
        .DEPTH(DEPTH), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO), .FILL_BYTE(FILL)
    ) dut (
        .Clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];
    logic [7:0] exp_tx[$];
    logic       exp_underrun = 0, exp_overflow = 0, exp_timeout = 0;
    int         due_inicio = 0, exp_done_cyc = 0, burst_len = 0, rx_seen = 0;
    bit         done_pending = 0, silent = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Loopback byte engine: answers each start pulse after a random delay.
    initial begin
        logic [7:0] b;
        int d;
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.o_inicio && !silent && !rst) begin
                b = bus.o_TX_Byte;
                d = $urandom_range(1, 6);
                repeat (d) @(posedge clk);
                #1;
                bus.i_RX_DV   = 1'b1;
                bus.i_RX_Byte = b ^ 8'hFF;
                rx_seen++;
                if (rx_seen == burst_len) exp_done_cyc = cyc + 1;
                else                      due_inicio   = cyc + GAP + 2;
                @(posedge clk);
                #1;
                bus.i_RX_DV = 1'b0;
            end
        end
    end

    // Monitor: pops the expected byte on every start pulse, checks done timing.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_inicio) begin
                    check("inicio_expected", 32'(exp_tx.size() != 0), 32'd1);
                    if (exp_tx.size() != 0) begin
                        check("tx_byte", 32'(bus.o_TX_Byte), 32'(exp_tx.pop_front()));
                        check("inicio_time", 32'(cyc), 32'(due_inicio));
                    end
                    if (silent) exp_done_cyc = cyc + TMO;
                end
                if (bus.o_done) begin
                    check("done_expected", 32'(done_pending), 32'd1);
                    if (done_pending) begin
                        check("done_time", 32'(cyc), 32'(exp_done_cyc));
                        done_pending = 0;
                    end
                end
            end
        end
    end

    task automatic write_bytes(input int n, input bit fixed, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = fixed ? ((i == 0) ? b0 : b1) : 8'($urandom);
            bus.i_wr_en   = 1'b1;
            bus.i_wr_data = b;
            if (tx_model.size() < DEPTH) tx_model.push_back(b);
            @(posedge clk);
            #1;
        end
        bus.i_wr_en = 1'b0;
    endtask

    task automatic start_burst(input int len, input bit sil);
        logic [7:0] b;
        silent    = sil;
        burst_len = len;
        rx_seen   = 0;
        for (int i = 0; i < len; i++) begin
            if (tx_model.size() != 0) b = tx_model.pop_front();
            else begin
                b = FILL;
                exp_underrun = 1'b1;
            end
            exp_tx.push_back(b);
            if (!sil) begin
                if (rx_model.size() < DEPTH) rx_model.push_back(b ^ 8'hFF);
                else                         exp_overflow = 1'b1;
            end
        end
        if (sil) exp_timeout = 1'b1;
        @(posedge clk);
        #1;
        bus.i_go     = 1'b1;
        bus.i_len    = 8'(len);
        due_inicio   = cyc + 2;
        done_pending = 1;
        if (len == 0) exp_done_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.i_go = 1'b0;
    endtask

    task automatic finish_burst(input string tag);
        int n = 0;
        while (done_pending && n < TMO + 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_done_seen"}, 32'(done_pending), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_all_sent"}, 32'(exp_tx.size()), 32'd0);
        check({tag, "_underrun"}, 32'(bus.o_underrun), 32'(exp_underrun));
        check({tag, "_overflow"}, 32'(bus.o_overflow), 32'(exp_overflow));
        check({tag, "_timeout"}, 32'(bus.o_timeout), 32'(exp_timeout));
    endtask

    task automatic drain_rx(input string tag);
        while (rx_model.size() != 0) begin
            check({tag, "_rx_not_empty"}, 32'(bus.o_rx_empty), 32'd0);
            check({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'(rx_model.pop_front()));
            bus.i_rd_en = 1'b1;
            @(posedge clk);
            #1;
            bus.i_rd_en = 1'b0;
        end
        check({tag, "_rx_empty"}, 32'(bus.o_rx_empty), 32'd1);
    endtask

    task automatic clear_errors(input string tag);
        bus.i_clr_err = 1'b1;
        @(posedge clk);
        #1;
        bus.i_clr_err = 1'b0;
        exp_underrun  = 1'b0;
        exp_overflow  = 1'b0;
        exp_timeout   = 1'b0;
        check({tag, "_flags_clear"}, 32'({bus.o_underrun, bus.o_overflow, bus.o_timeout}), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_inicio"}, 32'(bus.o_inicio), 32'd0);
        check({tag, "_tx_byte"}, 32'(bus.o_TX_Byte), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.o_rd_data), 32'd0);
        check({tag, "_tx_full"}, 32'(bus.o_tx_full), 32'd0);
        check({tag, "_rx_empty"}, 32'(bus.o_rx_empty), 32'd1);
        check({tag, "_flags"}, 32'({bus.o_underrun, bus.o_overflow, bus.o_timeout}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = 8'h00;
        bus.i_rd_en   = 1'b0;
        bus.i_go      = 1'b0;
        bus.i_len     = 8'h00;
        bus.i_clr_err = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-byte loopback burst
        write_bytes(2, 1'b1, 8'hA5, 8'h3C);
        start_burst(2, 1'b0);
        finish_burst("loop2");
        drain_rx("loop2");

        // Underrun: one byte queued, three requested
        write_bytes(1, 1'b0, 8'h00, 8'h00);
        start_burst(3, 1'b0);
        finish_burst("under");
        drain_rx("under");
        clear_errors("under");

        // Overflow: fill RX FIFO then run one more byte
        write_bytes(DEPTH, 1'b0, 8'h00, 8'h00);
        start_burst(DEPTH, 1'b0);
        finish_burst("fill");
        write_bytes(1, 1'b0, 8'h00, 8'h00);
        start_burst(1, 1'b0);
        finish_burst("over");
        drain_rx("over");
        clear_errors("over");

        // Timeout: engine never answers
        write_bytes(1, 1'b0, 8'h00, 8'h00);
        start_burst(1, 1'b1);
        finish_burst("tmo");
        clear_errors("tmo");

        // TX full: the DEPTH+1-th write is dropped
        write_bytes(DEPTH, 1'b0, 8'h00, 8'h00);
        check("tx_full_at_depth", 32'(bus.o_tx_full), 32'd1);
        write_bytes(1, 1'b0, 8'h00, 8'h00);
        check("tx_full_after_extra", 32'(bus.o_tx_full), 32'd1);
        start_burst(DEPTH + 1, 1'b0);
        finish_burst("full");
        check("tx_not_full_after", 32'(bus.o_tx_full), 32'd0);
        drain_rx("full");
        clear_errors("full");

        // Reset while waiting for the engine
        write_bytes(3, 1'b0, 8'h00, 8'h00);
        start_burst(1, 1'b1);
        n = 0;
        while (exp_tx.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tx_model.delete();
        rx_model.delete();
        exp_tx.delete();
        done_pending = 0;
        exp_underrun = 0;
        exp_overflow = 0;
        exp_timeout  = 0;
        silent       = 0;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        write_bytes(1, 1'b0, 8'h00, 8'h00);
        start_burst(1, 1'b0);
        finish_burst("postrst");
        drain_rx("postrst");

        // Zero-length burst
        start_burst(0, 1'b0);
        finish_burst("len0");

        // Randomized bursts
        for (int it = 0; it < 10; it++) begin
            write_bytes($urandom_range(0, 6), 1'b0, 8'h00, 8'h00);
            start_burst($urandom_range(1, 6), 1'b0);
            finish_burst("rand");
            drain_rx("rand");
            if (($urandom & 1) != 0) clear_errors("rand");
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
